// File: rtl/rfifo_rd_arb_pkg.sv
// Shared types and defaults for the FIFO read-port burst arbiter.
// Imported by the interface, the picker and the top.
package rfifo_rd_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 8;
    localparam int LW_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_t;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rfifo_rd_arb_if.sv
// Bundle of requester, FIFO read-port and output-stream signals.
// master drives requests and FIFO status; slave is the arbiter.
interface rfifo_rd_arb_if
    import rfifo_rd_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int LW   = LW_DEF
);
    localparam int IW = idw(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*LW-1:0] req_len;
    logic               rempty;
    logic [DW-1:0]      rdata;
    logic               rinc;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      dout;
    logic               dout_vld;
    logic [IW-1:0]      dout_id;
    logic               burst_done;
    logic               abort;

    modport master (
        output req, req_len, rempty, rdata,
        input  rinc, gnt, dout, dout_vld,
        input  dout_id, burst_done, abort
    );

    modport slave (
        input  req, req_len, rempty, rdata,
        output rinc, gnt, dout, dout_vld,
        output dout_id, burst_done, abort
    );

endinterface

// File: rtl/rfifo_rd_arb_rr_pick.sv
// Combinational round-robin picker: first eligible
// requester at or after ptr_i, wrapping modulo NREQ.
module rfifo_rd_arb_rr_pick
    import rfifo_rd_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = idw(NREQ_DEF)
) (
    input  logic [NREQ-1:0] elig_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] onehot_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    // Scan from the pointer and stop at the first hit.
    always_comb begin
        int j;
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        j        = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!any_o && elig_i[j]) begin
                any_o       = 1'b1;
                idx_o       = IW'(j);
                onehot_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rfifo_rd_arb.sv
// Round-robin burst arbiter for a shared FIFO read port.
// IDLE picks, BURST pops one word per cycle, DONE reports.
module rfifo_rd_arb
    import rfifo_rd_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int LW   = LW_DEF
) (
    input logic          rclk,
    input logic          rrst_n,
    rfifo_rd_arb_if.slave bus
);

    localparam int IW = idw(NREQ);

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   cur_id_q, cur_id_d;
    logic [LW-1:0]   remain_q, remain_d;
    logic            abort_q, abort_d;
    logic [DW-1:0]   dout_q;
    logic            dout_vld_q;
    logic [IW-1:0]   dout_id_q;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] win_oh;
    logic [IW-1:0]   win_idx;
    logic            win_any;
    logic [LW-1:0]   win_len;
    logic            cur_req;
    logic            pop;
    logic [IW-1:0]   nxt_ptr;
    logic [NREQ-1:0] gnt_c;

    // Zero-length requests never compete.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++)
            elig[i] = bus.req[i] &&
                      (bus.req_len[i*LW +: LW] != '0);
    end

    rfifo_rd_arb_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .elig_i   (elig),
        .ptr_i    (rr_ptr_q),
        .onehot_o (win_oh),
        .idx_o    (win_idx),
        .any_o    (win_any)
    );

    // Length of the winning requester, muxed by one-hot.
    always_comb begin
        win_len = '0;
        for (int i = 0; i < NREQ; i++)
            if (win_oh[i])
                win_len |= bus.req_len[i*LW +: LW];
    end

    assign cur_req = bus.req[cur_id_q];
    assign pop     = (state_q == BURST) && cur_req &&
                     !bus.rempty && (remain_q != '0);
    assign nxt_ptr = (cur_id_q == IW'(NREQ - 1)) ?
                     '0 : cur_id_q + IW'(1);

    // Next-state and bookkeeping for the burst FSM.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cur_id_d = cur_id_q;
        remain_d = remain_q;
        abort_d  = abort_q;
        unique case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (win_any) begin
                    state_d  = BURST;
                    cur_id_d = win_idx;
                    remain_d = win_len;
                end
            end
            BURST: begin
                if (!cur_req) begin
                    state_d = DONE;
                    abort_d = 1'b1;
                end else if (pop) begin
                    remain_d = remain_q - LW'(1);
                    if (remain_q == LW'(1))
                        state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                rr_ptr_d = nxt_ptr;
                remain_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and arbitration state registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cur_id_q <= '0;
            remain_q <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cur_id_q <= cur_id_d;
            remain_q <= remain_d;
            abort_q  <= abort_d;
        end
    end

    // Capture each popped word one cycle after the pop.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            dout_id_q  <= '0;
        end else begin
            dout_vld_q <= pop;
            if (pop) begin
                dout_q    <= bus.rdata;
                dout_id_q <= cur_id_q;
            end
        end
    end

    // Grant is a decode of the owner while bursting.
    always_comb begin
        gnt_c = '0;
        if (state_q == BURST)
            gnt_c[cur_id_q] = 1'b1;
    end

    assign bus.gnt        = gnt_c;
    assign bus.rinc       = pop;
    assign bus.dout       = dout_q;
    assign bus.dout_vld   = dout_vld_q;
    assign bus.dout_id    = dout_id_q;
    assign bus.burst_done = (state_q == DONE);
    assign bus.abort      = (state_q == DONE) && abort_q;

endmodule
